// File: rtl/table_rd_pkg.sv
// table_rd_pkg: shared FSM type and sizing helpers for the table read-stream controller
package table_rd_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction
endpackage

// File: rtl/table_rd_fifo.sv
// table_rd_fifo: show-ahead FIFO with registered storage and synchronous flush
module table_rd_fifo
  import table_rd_pkg::*;
#(
  parameter int DW = 9,
  parameter int DEPTH = 2,
  localparam int AW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rd_ptr];
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/table_rd_stream.sv
// table_rd_stream: streams a range of table_ram entries as valid/ready beats,
// hiding the fixed RAM read latency behind a small credit-limited FIFO.
module table_rd_stream
  import table_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);
  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int CW = clog2(FIFO_DEPTH + 1);
  state_t state;
  logic [ADDR_WIDTH:0] remaining, len_q, beat_cnt;
  logic [RD_LATENCY-1:0] flags;
  logic [CW-1:0] count, in_flight;
  logic accept, zero_cmd, issue, pop, fin;
  assign busy = state != IDLE;
  assign accept = state == IDLE && start && !abort && length != '0;
  assign zero_cmd = state == IDLE && start && !abort && length == '0;
  assign m_valid = count != '0;
  assign pop = m_valid && m_ready;
  assign m_last = m_valid && beat_cnt == len_q - 1'b1;
  assign fin = pop && m_last;
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + CW'(flags[i]);
  end
  // a beat leaving this cycle frees its slot long before the read issued now lands
  assign issue = state == READ && !abort &&
                 ({1'b0, in_flight} + {1'b0, count} < {1'b0, CW'(FIFO_DEPTH)} + {{CW{1'b0}}, pop});
  table_rd_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(flags[RD_LATENCY-1]),
    .pop(pop),
    .flush(abort),
    .din(ram_rd_data),
    .dout(m_data),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ram_rd_addr <= '0;
      remaining <= '0;
      len_q <= '0;
      beat_cnt <= '0;
      flags <= '0;
      done <= 1'b0;
    end else begin
      done <= zero_cmd || (fin && !abort);
      flags <= abort ? '0 : RD_LATENCY'({flags, issue});
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      if (abort) state <= IDLE;
      else if (accept) begin
        state <= READ;
        ram_rd_addr <= base_addr;
        remaining <= length;
        len_q <= length;
        beat_cnt <= '0;
      end else begin
        if (issue) begin
          ram_rd_addr <= ram_rd_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        if (issue && remaining == (ADDR_WIDTH + 1)'(1)) state <= DRAIN;
        if (state == DRAIN && fin) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_table_rd_stream.sv
// tb_table_rd_stream: directed checks of table_rd_stream at read latencies 1 and 2,
// both instances driven by the same command and ready stimulus.
module tb_table_rd_stream;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic start = 0, abort = 0, pat_on = 0, m_ready = 1;
  logic [8:0] base_addr = 0;
  logic [9:0] length = 0;
  logic [1:0] busy, done, m_valid, m_last;
  logic [8:0] rd_addr [2], rd_data [2], m_data [2];
  logic [8:0] ram0, ram1a, ram1b;
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  // RAM contents are RAM[a] = a; latency 1 and latency 2 models
  always @(posedge clk) begin
    ram0 <= rd_addr[0];
    ram1a <= rd_addr[1];
    ram1b <= ram1a;
  end
  assign rd_data[0] = ram0;
  assign rd_data[1] = ram1b;
  table_rd_stream #(.ADDR_WIDTH(9), .DATA_WIDTH(9), .RD_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy[0]), .done(done[0]), .ram_rd_addr(rd_addr[0]),
    .ram_rd_data(rd_data[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready), .m_last(m_last[0]));
  table_rd_stream #(.ADDR_WIDTH(9), .DATA_WIDTH(9), .RD_LATENCY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy[1]), .done(done[1]), .ram_rd_addr(rd_addr[1]),
    .ram_rd_data(rd_data[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready), .m_last(m_last[1]));
  int pc = 0;
  always @(posedge clk) begin
    #1;
    m_ready = pat_on ? (pc % 3 == 0) : 1'b1;
    pc++;
  end
  logic [9:0] beats [2][600];
  int nb [2], ndone [2], nvalid [2], maxc [2];
  logic prev_stall [2] = '{1'b0, 1'b0};
  logic prev_l [2];
  logic [8:0] prev_d [2];
  logic prev_abort = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int c;
      if (rst_n && !prev_abort && prev_stall[k]) begin
        check($sformatf("stall_valid%0d", k), m_valid[k], 1);
        check($sformatf("stall_data%0d", k), m_data[k], prev_d[k]);
        check($sformatf("stall_last%0d", k), m_last[k], prev_l[k]);
      end
      if (rst_n && !abort && m_valid[k] && m_ready) begin
        beats[k][nb[k]] = {m_last[k], m_data[k]};
        nb[k]++;
      end
      if (done[k]) ndone[k]++;
      if (m_valid[k]) nvalid[k]++;
      c = (k == 0) ? int'(u0.u_fifo.count) : int'(u1.u_fifo.count);
      if (c > maxc[k]) maxc[k] = c;
      prev_stall[k] = rst_n && m_valid[k] && !m_ready;
      prev_d[k] = m_data[k];
      prev_l[k] = m_last[k];
    end
    prev_abort = abort;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0;
      ndone[k] = 0;
      nvalid[k] = 0;
      maxc[k] = 0;
    end
  endtask
  task automatic cmd(input logic [8:0] b, input logic [9:0] l);
    base_addr = b;
    length = l;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy != 0 || m_valid != 0) && n < bound) begin
      tick();
      n++;
    end
    check("idle_in_time", n < bound, 1);
    repeat (2) tick();
  endtask
  task automatic expect_burst(input int k, input int b, input int l);
    check($sformatf("beat_count%0d", k), nb[k], l);
    for (int i = 0; i < l && i < nb[k]; i++) begin
      check($sformatf("beat_data%0d_%0d", k, i), beats[k][i][8:0], (b + i) % 512);
      check($sformatf("beat_last%0d_%0d", k, i), beats[k][i][9], i == l - 1);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_busy"}, busy[k], 0);
      check({tag, "_done"}, done[k], 0);
      check({tag, "_valid"}, m_valid[k], 0);
      check({tag, "_last"}, m_last[k], 0);
      check({tag, "_addr"}, rd_addr[k], 0);
      check({tag, "_data"}, m_data[k], 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end
  initial begin
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    // basic burst, cycle-exact on the latency-1 instance
    clear();
    cmd(5, 4);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", i), m_valid[0], i >= 2 && i <= 5);
      if (i >= 2 && i <= 5) check($sformatf("t1_data_c%0d", i), m_data[0], 5 + i - 2);
      check($sformatf("t1_last_c%0d", i), m_last[0], i == 5);
      check($sformatf("t1_done_c%0d", i), done[0], i == 6);
      check($sformatf("t1_busy_c%0d", i), busy[0], i < 6);
    end
    wait_idle(50);
    expect_burst(0, 5, 4);
    expect_burst(1, 5, 4);
    check("t1_ndone0", ndone[0], 1);
    check("t1_ndone1", ndone[1], 1);
    // wrap-around, with a start issued mid-burst that must be ignored
    clear();
    cmd(510, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_addr%0d", i), rd_addr[0], (510 + i) % 512);
    end
    tick();
    cmd(100, 3);
    wait_idle(50);
    expect_burst(0, 510, 4);
    expect_burst(1, 510, 4);
    check("t2_ndone0", ndone[0], 1);
    check("t2_ndone1", ndone[1], 1);
    // backpressure pattern 1,0,0
    clear();
    pat_on = 1;
    cmd(20, 8);
    wait_idle(200);
    pat_on = 0;
    expect_burst(0, 20, 8);
    expect_burst(1, 20, 8);
    check("t3_fifo_bound0", maxc[0] <= 2, 1);
    check("t3_fifo_bound1", maxc[1] <= 3, 1);
    check("t3_ndone0", ndone[0], 1);
    // zero-length command
    clear();
    cmd(9, 0);
    @(negedge clk);
    check("t4_done0", done[0], 1);
    check("t4_done1", done[1], 1);
    check("t4_busy0", busy[0], 0);
    @(negedge clk);
    check("t4_done_clear", done[0], 0);
    repeat (4) tick();
    check("t4_nvalid0", nvalid[0], 0);
    check("t4_nvalid1", nvalid[1], 0);
    check("t4_ndone0", ndone[0], 1);
    // abort after three beats
    clear();
    cmd(0, 16);
    begin
      int n = 0;
      while (nb[0] < 3 && n < 100) begin
        tick();
        n++;
      end
      check("t5_reach3", nb[0], 3);
    end
    abort = 1;
    tick();
    abort = 0;
    @(negedge clk);
    check("t5_valid_after_abort", m_valid[0], 0);
    check("t5_busy_after_abort", busy[0], 0);
    repeat (10) tick();
    check("t5_no_stray", nb[0], 3);
    check("t5_ndone0", ndone[0], 0);
    check("t5_ndone1", ndone[1], 0);
    // abort together with start in IDLE drops the command
    clear();
    base_addr = 0;
    length = 2;
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    @(negedge clk);
    check("t5_abort_start_busy", busy[0], 0);
    repeat (3) tick();
    check("t5_abort_start_done", ndone[0], 0);
    check("t5_abort_start_valid", nvalid[0], 0);
    clear();
    cmd(0, 2);
    wait_idle(50);
    expect_burst(0, 0, 2);
    expect_burst(1, 0, 2);
    check("t5_ndone0", ndone[0], 1);
    // asynchronous reset mid-burst
    clear();
    cmd(40, 8);
    begin
      int n = 0;
      while (!m_valid[0] && n < 20) begin
        tick();
        n++;
      end
      check("t6_valid_seen", m_valid[0], 1);
    end
    rst_n = 0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) tick();
    rst_n = 1;
    tick();
    check("t6_no_done0", ndone[0], 0);
    check("t6_no_done1", ndone[1], 0);
    clear();
    cmd(3, 3);
    wait_idle(50);
    expect_burst(0, 3, 3);
    expect_burst(1, 3, 3);
    check("t6_ndone0", ndone[0], 1);
    // full table once
    clear();
    cmd(7, 512);
    wait_idle(1200);
    expect_burst(0, 7, 512);
    expect_burst(1, 7, 512);
    check("t7_ndone0", ndone[0], 1);
    check("t7_ndone1", ndone[1], 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
